// File: rtl/pe_psum_drain.sv
// ---------------------------------------------------------------------------
// pe_psum_drain
//
// Reader side of the PE output psum FIFO. Pops 3x6 psum tiles, accumulates a
// configurable number of consecutive tiles (input channels) into an
// 18-entry signed accumulator, requantizes the result to 8-bit activations
// and streams it out one tile row (6 activations) per valid/ready beat.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   en_i           drain enable (level); only honoured at group boundaries
//   ch_cnt_i       tiles per output tile (0 -> 1, >MAX_CH -> MAX_CH)
//   shift_i        arithmetic right shift applied before saturation
//   relu_en_i      1: ReLU + unsigned 8-bit saturation, 0: signed 8-bit sat
//   fifo_empty_i   PE FIFO empty
//   fifo_rd_en_o   PE FIFO pop; data appears on fifo_dout_i next cycle
//   fifo_dout_i    tile, element (r,c) at [(r*6+c)*PSUM_WIDTH +: PSUM_WIDTH]
//   act_o          one tile row, column c at [c*8 +: 8]
//   act_row_o      row index of the current beat
//   act_valid_o    act_o / act_row_o valid
//   act_ready_i    downstream accept
//   busy_o         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module pe_psum_drain #(
    parameter int PSUM_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_CH     = 8,
    parameter int CH_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [CH_W-1:0]          ch_cnt_i,
    input  logic [4:0]               shift_i,
    input  logic                     relu_en_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_en_o,
    input  logic [18*PSUM_WIDTH-1:0] fifo_dout_i,
    output logic [47:0]              act_o,
    output logic [1:0]               act_row_o,
    output logic                     act_valid_o,
    input  logic                     act_ready_i,
    output logic                     busy_o
);

    localparam int ROWS = 3;
    localparam int COLS = 6;
    localparam int TILE = ROWS * COLS;

    localparam logic signed [ACC_WIDTH-1:0] U8_MAX = ACC_WIDTH'(255);
    localparam logic signed [ACC_WIDTH-1:0] S8_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] S8_MIN = ACC_WIDTH'(-128);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACC   = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Control
    logic            pop;
    logic            latch_cfg;
    logic            last_ch;
    logic [CH_W-1:0] ch;
    logic [1:0]      row;

    // Group configuration, captured at each group start
    logic [CH_W-1:0] cfg_ch;
    logic [4:0]      cfg_shift;
    logic            cfg_relu;

    // Datapath
    logic signed [ACC_WIDTH-1:0] psum_ext [TILE];
    logic signed [ACC_WIDTH-1:0] acc      [TILE];
    logic [4:0]                  row_base;
    logic [4:0]                  sel;

    // Channel count sanitising: 0 means a single tile, oversize clamps.
    function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] c);
        if (c == '0) begin
            return CH_W'(1);
        end else if (c > CH_W'(MAX_CH)) begin
            return CH_W'(MAX_CH);
        end else begin
            return c;
        end
    endfunction

    // Shift then saturate one accumulator to an 8-bit activation.
    function automatic logic [7:0] requant(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [4:0]                  sh,
        input logic                        relu
    );
        logic signed [ACC_WIDTH-1:0] t;
        t = a >>> sh;
        if (relu) begin
            if (t[ACC_WIDTH-1]) begin
                return 8'h00;
            end else if (t > U8_MAX) begin
                return 8'hFF;
            end else begin
                return t[7:0];
            end
        end else begin
            if (t > S8_MAX) begin
                return 8'h7F;
            end else if (t < S8_MIN) begin
                return 8'h80;
            end else begin
                return t[7:0];
            end
        end
    endfunction

    assign last_ch = (ch == cfg_ch - CH_W'(1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        latch_cfg = 1'b0;
        case (state)
            IDLE: begin
                if (en_i) begin
                    state_nxt = FETCH;
                    latch_cfg = 1'b1;
                end
            end
            FETCH: begin
                // Disable only takes effect between groups; the abort has
                // priority so a tile is never popped and then dropped.
                if ((ch == '0) && !en_i) begin
                    state_nxt = IDLE;
                end else if (!fifo_empty_i) begin
                    pop       = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                state_nxt = last_ch ? EMIT : FETCH;
            end
            EMIT: begin
                if (act_ready_i && (row == 2'd2)) begin
                    if (en_i) begin
                        state_nxt = FETCH;
                        latch_cfg = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_rd_en_o = pop;
    assign act_valid_o  = (state == EMIT);
    assign busy_o       = (state != IDLE);
    assign act_row_o    = row;

    // ------------------------------------------------------------------
    // Configuration latch, channel and row counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ch    <= '0;
            cfg_shift <= '0;
            cfg_relu  <= 1'b0;
        end else if (latch_cfg) begin
            cfg_ch    <= clamp_ch(ch_cnt_i);
            cfg_shift <= shift_i;
            cfg_relu  <= relu_en_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch <= '0;
        end else if (latch_cfg) begin
            ch <= '0;
        end else if (state == ACC) begin
            ch <= last_ch ? '0 : ch + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= 2'd0;
        end else if ((state == EMIT) && act_ready_i) begin
            row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // FETCH -> ACC: unpack and sign-extend the popped tile
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < TILE; k++) begin
            psum_ext[k] = {{(ACC_WIDTH-PSUM_WIDTH){fifo_dout_i[k*PSUM_WIDTH+PSUM_WIDTH-1]}},
                           fifo_dout_i[k*PSUM_WIDTH +: PSUM_WIDTH]};
        end
    end

    // ------------------------------------------------------------------
    // ACC: first channel overwrites, later channels add (wraps on overflow)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TILE; k++) begin
                acc[k] <= '0;
            end
        end else if (state == ACC) begin
            for (int k = 0; k < TILE; k++) begin
                acc[k] <= (ch == '0) ? psum_ext[k] : acc[k] + psum_ext[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // EMIT: requantize the selected row; acc is frozen here, so act_o is
    // stable for as long as the beat is stalled.
    // ------------------------------------------------------------------
    always_comb begin
        act_o    = '0;
        sel      = '0;
        row_base = (row == 2'd2) ? 5'd12 : (row == 2'd1) ? 5'd6 : 5'd0;
        if (state == EMIT) begin
            for (int c = 0; c < COLS; c++) begin
                sel            = row_base + 5'(c);
                act_o[c*8 +: 8] = requant(acc[sel], cfg_shift, cfg_relu);
            end
        end
    end

endmodule

// File: tb/tb_pe_psum_drain.sv
// ---------------------------------------------------------------------------
// tb_pe_psum_drain
//
// Directed bench for pe_psum_drain: a table of single-group vectors with
// hand-computed rows, followed by hand-written sequences for backpressure,
// FIFO-empty gaps and reset in the middle of a group.
// ---------------------------------------------------------------------------
module tb_pe_psum_drain;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int MC = 8;
    localparam int CW = 4;
    localparam int BUDGET = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic [CW-1:0]     ch_cnt_i;
    logic [4:0]        shift_i;
    logic              relu_en_i;
    logic              fifo_empty_i;
    logic              fifo_rd_en_o;
    logic [18*PW-1:0]  fifo_dout_i = '0;
    logic [47:0]       act_o;
    logic [1:0]        act_row_o;
    logic              act_valid_o;
    logic              act_ready_i;
    logic              busy_o;

    pe_psum_drain #(
        .PSUM_WIDTH(PW),
        .ACC_WIDTH (AW),
        .MAX_CH    (MC),
        .CH_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .ch_cnt_i    (ch_cnt_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .fifo_dout_i (fifo_dout_i),
        .act_o       (act_o),
        .act_row_o   (act_row_o),
        .act_valid_o (act_valid_o),
        .act_ready_i (act_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Simple FIFO model: written by the test, popped by the DUT.
    logic [18*PW-1:0] mem [64];
    int wr_cnt = 0;
    int rd_cnt = 0;

    assign fifo_empty_i = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en_o && !fifo_empty_i) begin
            fifo_dout_i <= mem[rd_cnt % 64];
            rd_cnt      <= rd_cnt + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CW-1:0] ch_cnt;
        int            ntiles;
        logic [4:0]    shift;
        logic          relu;
        int            base;
        int            stp;
        logic [47:0]   exp0;
        logic [47:0]   exp1;
        logic [47:0]   exp2;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("rd_en_while_empty", 64'(fifo_rd_en_o & fifo_empty_i), 64'd0);
    endtask

    function automatic logic [18*PW-1:0] make_tile(input int base, input int stp);
        logic [18*PW-1:0] t;
        t = '0;
        for (int k = 0; k < 18; k++) begin
            t[k*PW +: PW] = 16'(base + stp * k);
        end
        return t;
    endfunction

    task automatic push_tile(input logic [18*PW-1:0] t);
        mem[wr_cnt % 64] = t;
        wr_cnt++;
    endtask

    // Accept three beats with ready held high; optionally drop en_i during
    // the final beat so the FSM returns to IDLE.
    task automatic collect(input string name, input logic [47:0] e0, input logic [47:0] e1,
                           input logic [47:0] e2, input bit drop_en);
        logic [47:0] e [3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        for (int r = 0; r < 3; r++) begin
            int n;
            n = 0;
            while (!act_valid_o && n < BUDGET) begin
                step();
                n++;
            end
            check($sformatf("%s valid%0d", name, r), 64'(act_valid_o), 64'd1);
            if (!act_valid_o) return;
            check($sformatf("%s row%0d idx", name, r), 64'(act_row_o), 64'(r));
            check($sformatf("%s row%0d data", name, r), 64'(act_o), 64'(e[r]));
            if (r == 2 && drop_en) en_i = 1'b0;
            step();
        end
    endtask

    task automatic wait_pops(input string name, input int target);
        int n;
        n = 0;
        while (rd_cnt != target && n < BUDGET) begin
            step();
            n++;
        end
        check({name, " pop wait"}, 64'(rd_cnt), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;

        vecs[0]  = '{4'd1,  1, 5'd0, 1'b0, -9,    1, 48'hFCFBFAF9F8F7, 48'h020100FFFEFD, 48'h080706050403};
        vecs[1]  = '{4'd4,  4, 5'd2, 1'b1, 100,   0, 48'h646464646464, 48'h646464646464, 48'h646464646464};
        vecs[2]  = '{4'd1,  1, 5'd0, 1'b1, -50,   0, 48'h000000000000, 48'h000000000000, 48'h000000000000};
        vecs[3]  = '{4'd1,  1, 5'd0, 1'b0, 300,   0, 48'h7F7F7F7F7F7F, 48'h7F7F7F7F7F7F, 48'h7F7F7F7F7F7F};
        vecs[4]  = '{4'd1,  1, 5'd0, 1'b0, -300,  0, 48'h808080808080, 48'h808080808080, 48'h808080808080};
        vecs[5]  = '{4'd1,  1, 5'd0, 1'b1, 300,   0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
        vecs[6]  = '{4'd1,  1, 5'd0, 1'b1, -300,  0, 48'h000000000000, 48'h000000000000, 48'h000000000000};
        vecs[7]  = '{4'd1,  1, 5'd0, 1'b0, -300, 40, 48'h9C8080808080, 48'h7F643C14ECC4, 48'h7F7F7F7F7F7F};
        vecs[8]  = '{4'd0,  1, 5'd0, 1'b0, 5,     0, 48'h050505050505, 48'h050505050505, 48'h050505050505};
        vecs[9]  = '{4'd15, 8, 5'd3, 1'b0, 10,    0, 48'h0A0A0A0A0A0A, 48'h0A0A0A0A0A0A, 48'h0A0A0A0A0A0A};
        vecs[10] = '{4'd2,  2, 5'd1, 1'b0, -7,    0, 48'hF9F9F9F9F9F9, 48'hF9F9F9F9F9F9, 48'hF9F9F9F9F9F9};
        vecs[11] = '{4'd1,  1, 5'd1, 1'b0, -3,    0, 48'hFEFEFEFEFEFE, 48'hFEFEFEFEFEFE, 48'hFEFEFEFEFEFE};
        vecs[12] = '{4'd3,  3, 5'd4, 1'b1, 1000,  0, 48'hBBBBBBBBBBBB, 48'hBBBBBBBBBBBB, 48'hBBBBBBBBBBBB};
        vecs[13] = '{4'd2,  2, 5'd0, 1'b0, 0,     3, 48'h1E18120C0600, 48'h423C36302A24, 48'h66605A544E48};

        rst         = 1'b1;
        en_i        = 1'b0;
        ch_cnt_i    = '0;
        shift_i     = '0;
        relu_en_i   = 1'b0;
        act_ready_i = 1'b1;
        step();
        step();
        check("reset busy",  64'(busy_o),       64'd0);
        check("reset valid", 64'(act_valid_o),  64'd0);
        check("reset rd_en", 64'(fifo_rd_en_o), 64'd0);
        check("reset act",   64'(act_o),        64'd0);
        check("reset row",   64'(act_row_o),    64'd0);
        rst = 1'b0;
        step();

        // Table-driven single groups
        for (int i = 0; i < 14; i++) begin
            start     = rd_cnt;
            ch_cnt_i  = vecs[i].ch_cnt;
            shift_i   = vecs[i].shift;
            relu_en_i = vecs[i].relu;
            for (int t = 0; t < vecs[i].ntiles; t++) begin
                push_tile(make_tile(vecs[i].base, vecs[i].stp));
            end
            en_i = 1'b1;
            collect($sformatf("v%0d", i), vecs[i].exp0, vecs[i].exp1, vecs[i].exp2, 1'b1);
            check($sformatf("v%0d idle busy", i), 64'(busy_o), 64'd0);
            check($sformatf("v%0d pops", i), 64'(rd_cnt - start), 64'(vecs[i].ntiles));
            step();
        end

        // Backpressure on row 1 with the next tile already waiting
        ch_cnt_i  = 4'd1;
        shift_i   = 5'd0;
        relu_en_i = 1'b0;
        push_tile(make_tile(-9, 1));
        en_i = 1'b1;
        begin
            int n;
            n = 0;
            while (!act_valid_o && n < BUDGET) begin
                step();
                n++;
            end
        end
        check("bp row0 valid", 64'(act_valid_o), 64'd1);
        check("bp row0 data",  64'(act_o), 64'h0000FCFBFAF9F8F7);
        step();
        act_ready_i = 1'b0;
        push_tile(make_tile(7, 0));
        start = rd_cnt;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp hold valid", 64'(act_valid_o),  64'd1);
            check("bp hold row",   64'(act_row_o),    64'd1);
            check("bp hold data",  64'(act_o),        64'h0000020100FFFEFD);
            check("bp hold rd_en", 64'(fifo_rd_en_o), 64'd0);
        end
        check("bp no pops", 64'(rd_cnt - start), 64'd0);
        act_ready_i = 1'b1;
        step();
        check("bp row2 idx",  64'(act_row_o), 64'd2);
        check("bp row2 data", 64'(act_o), 64'h0000080706050403);
        step();
        check("bp next fetch busy",  64'(busy_o),       64'd1);
        check("bp next fetch rd_en", 64'(fifo_rd_en_o), 64'd1);
        collect("bp next", 48'h070707070707, 48'h070707070707, 48'h070707070707, 1'b1);
        check("bp idle busy", 64'(busy_o), 64'd0);
        step();

        // Three-tile group with empty gaps between tiles
        ch_cnt_i  = 4'd3;
        shift_i   = 5'd0;
        relu_en_i = 1'b0;
        start     = rd_cnt;
        en_i      = 1'b1;
        push_tile(make_tile(10, 0));
        for (int i = 1; i < 3; i++) begin
            wait_pops("gap", wr_cnt);
            for (int g = 0; g < 5; g++) begin
                step();
                check("gap rd_en", 64'(fifo_rd_en_o), 64'd0);
                check("gap busy",  64'(busy_o),       64'd1);
            end
            push_tile(make_tile(10 * (i + 1), 0));
        end
        collect("gap", 48'h3C3C3C3C3C3C, 48'h3C3C3C3C3C3C, 48'h3C3C3C3C3C3C, 1'b1);
        check("gap pops", 64'(rd_cnt - start), 64'd3);
        step();

        // Reset while accumulating the third channel of a four-tile group
        ch_cnt_i = 4'd4;
        start    = rd_cnt;
        for (int t = 0; t < 3; t++) push_tile(make_tile(1, 0));
        en_i = 1'b1;
        wait_pops("rst", start + 3);
        rst      = 1'b1;
        ch_cnt_i = 4'd1;
        step();
        check("rst busy",  64'(busy_o),       64'd0);
        check("rst valid", 64'(act_valid_o),  64'd0);
        check("rst rd_en", 64'(fifo_rd_en_o), 64'd0);
        check("rst act",   64'(act_o),        64'd0);
        check("rst row",   64'(act_row_o),    64'd0);
        rst   = 1'b0;
        start = rd_cnt;
        push_tile(make_tile(7, 0));
        collect("post rst", 48'h070707070707, 48'h070707070707, 48'h070707070707, 1'b1);
        check("post rst pops", 64'(rd_cnt - start), 64'd1);
        check("post rst busy", 64'(busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_psum_drain.md
Name: pe_psum_drain

Overview:
Reader side of the PE output psum FIFO. It pops 3x6 psum tiles, accumulates a configurable number of consecutive tiles (input channels) into an 18-entry accumulator, then requantizes them to 8-bit activations. Results stream out one tile row (6 activations) per valid/ready beat toward the activation buffer. There is one instance per PE.

Parameters:
PSUM_WIDTH, 16, width of one signed psum element in a FIFO entry
ACC_WIDTH, 24, signed accumulator width (must be >= PSUM_WIDTH + clog2(MAX_CH))
MAX_CH, 8, maximum channels accumulated per tile
CH_W, 4, width of channel-count config (clog2(MAX_CH)+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_i  in  1  drain enable; level-sensitive
ch_cnt_i  in  CH_W  tiles accumulated per output tile; sampled at group start; 0 is treated as 1, values >MAX_CH are clamped to MAX_CH
shift_i  in  5  arithmetic right shift applied before saturation; sampled at group start
relu_en_i  in  1  1: ReLU + unsigned saturation; 0: signed saturation; sampled at group start
fifo_empty_i  in  1  PE FIFO empty
fifo_rd_en_o  out  1  PE FIFO pop request
fifo_dout_i  in  18*PSUM_WIDTH  tile; element (r,c) at bits [(r*6+c)*PSUM_WIDTH +: PSUM_WIDTH], r=0..2, c=0..5
act_o  out  48  one tile row; column c at [c*8 +: 8]
act_row_o  out  2  row index r of current beat (0..2)
act_valid_o  out  1  act_o/act_row_o valid
act_ready_i  in  1  downstream accept
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high on rst. All state is updated on posedge clk.
- Reset values: state IDLE, fifo_rd_en_o=0, act_valid_o=0, act_o=0, act_row_o=0, busy_o=0, channel counter 0, accumulators 0, latched config 0/0/0.
- FIFO read timing: fifo_dout_i is valid the cycle after a cycle with fifo_rd_en_o=1 and fifo_empty_i=0. fifo_rd_en_o is combinational: (state==FETCH) && !fifo_empty_i. It is never asserted while empty.
- FSM:
  - IDLE: if en_i, latch ch_cnt/shift/relu_en, set ch=0, go to FETCH.
  - FETCH: if !fifo_empty_i, pop and go to ACC; otherwise stay.
  - ACC: for all 18 k, acc[k] <= (ch==0) ? sext(psum[k]) : acc[k]+sext(psum[k]). If ch==ch_cnt-1, set ch=0 and go to EMIT; otherwise ch++ and go to FETCH.
  - EMIT: present row r (starting r=0) with act_valid_o=1. On act_valid_o&&act_ready_i: if r<2, r++; if r==2, r=0 and go to FETCH when en_i, else IDLE.
  - Config is re-latched on every EMIT->FETCH and IDLE->FETCH transition only.
- Accumulator semantics: no psum-drop logic; accumulation wraps modulo 2^ACC_WIDTH (the sizing rule guarantees no overflow).
- Requant per element: t = acc >>> shift_i (arithmetic).
  - relu_en=1: out = t<0 ? 0 : (t>255 ? 255 : t).
  - relu_en=0: out = clamp(t,-128,127), two's complement.
- act_o is computed combinationally from acc and r. It must stay stable while act_valid_o=1 && !act_ready_i, because acc is not written in EMIT.
- Throughput: 2 cycles per popped tile (FETCH+ACC) at best, plus >=3 cycles per emitted tile.
- en_i deassert: takes effect only at group boundaries. A group in progress (ch>0 or EMIT) completes. en_i low in FETCH with ch==0 returns to IDLE without popping.
- Backpressure: act_ready_i low holds EMIT indefinitely. No FIFO pops occur during EMIT, so the PE FIFO fills and the PE stalls upstream.
- Reset mid-operation: immediate return to reset values. A tile popped in the same cycle is discarded, and partial accumulation is lost.

Test Plan:
- ch_cnt=1, shift=0, relu=0; one tile with element k = k-9 -> 3 beats, rows 0/1/2; row0 = {-9..-4}, row2 = {3..8}; fifo_rd_en_o pulses exactly once.
- ch_cnt=4, shift=2, relu=1; 4 tiles all elements 100 -> acc 400, out 100 in all 18 lanes; tile with all elements -50 (ch_cnt=1) -> all 0.
- Saturation: ch_cnt=1, shift=0; elements 300 and -300 -> relu=0 gives 127/-128, relu=1 gives 255/0.
- Backpressure: hold act_ready_i=0 for 10 cycles during row 1 -> act_o/act_row_o constant, no pops; release -> rows 1, 2 complete, next FETCH.
- FIFO empty gaps: 3-tile group with empty_i high 5 cycles between tiles -> no rd_en while empty; result equals the gap-free sum.
- ch_cnt_i=0 behaves as 1; ch_cnt_i=15 clamps to 8. rst pulse during ACC with ch=2 -> all outputs at reset values next cycle, busy_o=0, next group accumulates from zero.
